mod_updown_counter: RTL and testbench



---
 rtl/mod_updown_counter_if.sv | 33 +++
 rtl/mod_updown_counter.sv | 79 +++++++
 tb/tb_mod_updown_counter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter.
//   master : drives en, up, load, load_val; observes count, tc, wrap, ovf
//   slave  : the counter itself
// en       count enable
// up       direction, 1 = up, 0 = down
// load     synchronous parallel load (overrides en)
// load_val value to load, clamped to MODULUS-1 by the counter
// count    registered count value
// tc       combinational terminal count, used as the next stage's en
// wrap     one-cycle pulse after a wrapping edge
// ovf      sticky wrap/saturation flag, cleared by rst or load
interface mod_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up, load, load_val,
    input  count, tc, wrap, ovf
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tc, wrap, ovf
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised synchronous modulo-MODULUS up/down counter with enable,
// clamped parallel load, wrap or saturate behaviour at the range ends,
// cascade terminal count and sticky overflow.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active high (count <- RESET_VALUE)
//   bus  mod_updown_counter_if slave modport (see interface header)
// Edge priority: rst > load > en > hold.
module mod_updown_counter #(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 8,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mod_updown_counter_if.slave   bus
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH) ||
      RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_params
    $error("mod_updown_counter: illegal MODULUS/RESET_VALUE for WIDTH");
  end

  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bot, end_hit;

  assign at_top  = (count_q == TOP);
  assign at_bot  = (count_q == '0);
  // End of range in the currently requested direction.
  assign end_hit = bus.up ? at_top : at_bot;

  assign bus.tc    = bus.en & ~bus.load & end_hit;
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.ovf   = ovf_q;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (bus.load) begin
      // Compare in WIDTH+1 bits so MODULUS = 2^WIDTH is representable.
      count_d = ({1'b0, bus.load_val} < MOD_X) ? bus.load_val : TOP;
      ovf_d   = 1'b0;
    end else if (bus.en) begin
      if (end_hit) begin
        ovf_d = 1'b1;
        if (SATURATE == 0) begin
          count_d = bus.up ? '0 : TOP;
          wrap_d  = 1'b1;
        end
      end else if (bus.up) begin
        count_d = WIDTH'({1'b0, count_q} + 1'b1);
      end else begin
        count_d = WIDTH'({1'b0, count_q} - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_V;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(3)) b8 ();
  mod_updown_counter_if #(.WIDTH(3)) b6 ();
  mod_updown_counter_if #(.WIDTH(3)) bs ();
  mod_updown_counter_if #(.WIDTH(3)) bl ();
  mod_updown_counter_if #(.WIDTH(3)) bh ();

  mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .RESET_VALUE(0))
    u8 (.clk(clk), .rst(rst), .bus(b8));
  mod_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .RESET_VALUE(3))
    u6 (.clk(clk), .rst(rst), .bus(b6));
  mod_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1), .RESET_VALUE(0))
    us (.clk(clk), .rst(rst), .bus(bs));
  mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .RESET_VALUE(0))
    ulo (.clk(clk), .rst(rst), .bus(bl));
  mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .RESET_VALUE(0))
    uhi (.clk(clk), .rst(rst), .bus(bh));

  // Cascade: low stage terminal count enables the high stage.
  assign bh.en       = bl.tc;
  assign bh.up       = 1'b1;
  assign bh.load     = 1'b0;
  assign bh.load_val = '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    total++; if (b8.count !== 3'd0) begin bad++; $display("FAIL reset_count8: got %0d want 0", b8.count); end
    total++; if (b8.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap8: got %b want 0", b8.wrap); end
    total++; if (b8.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf8: got %b want 0", b8.ovf); end
    total++; if (b8.tc !== 1'b0) begin bad++; $display("FAIL reset_tc8: got %b want 0", b8.tc); end
    total++; if (b6.count !== 3'd3) begin bad++; $display("FAIL reset_count6_rv3: got %0d want 3", b6.count); end
    total++; if (bs.count !== 3'd0) begin bad++; $display("FAIL reset_count_sat: got %0d want 0", bs.count); end
    total++; if ({bh.count, bl.count} !== 6'd0) begin bad++; $display("FAIL reset_cascade: got %0d want 0", {bh.count, bl.count}); end
    rst = 1'b0;
  endtask

  task automatic test_up_count;
    int ec[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int et[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int ew[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int eo[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    b8.en = 1'b1; b8.up = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      total++; if (b8.tc !== et[i][0]) begin bad++; $display("FAIL up_tc step%0d: got %b want %0d", i, b8.tc, et[i]); end
      tick();
      total++; if (b8.count !== ec[i][2:0]) begin bad++; $display("FAIL up_count step%0d: got %0d want %0d", i, b8.count, ec[i]); end
      total++; if (b8.wrap !== ew[i][0]) begin bad++; $display("FAIL up_wrap step%0d: got %b want %0d", i, b8.wrap, ew[i]); end
      total++; if (b8.ovf !== eo[i][0]) begin bad++; $display("FAIL up_ovf step%0d: got %b want %0d", i, b8.ovf, eo[i]); end
    end
    b8.en = 1'b0;
  endtask

  task automatic test_down_count;
    int ec[7] = '{5, 4, 3, 2, 1, 0, 5};
    int et[7] = '{1, 0, 0, 0, 0, 0, 1};
    int ew[7] = '{1, 0, 0, 0, 0, 0, 1};
    b6.load = 1'b1; b6.load_val = 3'd0;
    tick();
    total++; if (b6.count !== 3'd0) begin bad++; $display("FAIL down_preload: got %0d want 0", b6.count); end
    b6.load = 1'b0; b6.en = 1'b1; b6.up = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      total++; if (b6.tc !== et[i][0]) begin bad++; $display("FAIL down_tc step%0d: got %b want %0d", i, b6.tc, et[i]); end
      tick();
      total++; if (b6.count !== ec[i][2:0]) begin bad++; $display("FAIL down_count step%0d: got %0d want %0d", i, b6.count, ec[i]); end
      total++; if (b6.wrap !== ew[i][0]) begin bad++; $display("FAIL down_wrap step%0d: got %b want %0d", i, b6.wrap, ew[i]); end
      total++; if (b6.ovf !== 1'b1) begin bad++; $display("FAIL down_ovf step%0d: got %b want 1", i, b6.ovf); end
    end
    b6.en = 1'b0;
  endtask

  task automatic test_saturate;
    int ec[10] = '{1, 2, 3, 4, 5, 5, 5, 5, 4, 3};
    int et[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    int eo[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    bs.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bs.up = (i < 8);
      #1;
      total++; if (bs.tc !== et[i][0]) begin bad++; $display("FAIL sat_tc step%0d: got %b want %0d", i, bs.tc, et[i]); end
      tick();
      total++; if (bs.count !== ec[i][2:0]) begin bad++; $display("FAIL sat_count step%0d: got %0d want %0d", i, bs.count, ec[i]); end
      total++; if (bs.wrap !== 1'b0) begin bad++; $display("FAIL sat_wrap step%0d: got %b want 0", i, bs.wrap); end
      total++; if (bs.ovf !== eo[i][0]) begin bad++; $display("FAIL sat_ovf step%0d: got %b want %0d", i, bs.ovf, eo[i]); end
    end
    // Hold at the bottom end: clear ovf by loading 0, then step down once.
    bs.load = 1'b1; bs.load_val = 3'd0;
    tick();
    total++; if (bs.ovf !== 1'b0) begin bad++; $display("FAIL sat_load_clr: got %b want 0", bs.ovf); end
    bs.load = 1'b0; bs.up = 1'b0;
    #1;
    total++; if (bs.tc !== 1'b1) begin bad++; $display("FAIL sat_bot_tc: got %b want 1", bs.tc); end
    tick();
    total++; if (bs.count !== 3'd0) begin bad++; $display("FAIL sat_bot_count: got %0d want 0", bs.count); end
    total++; if (bs.wrap !== 1'b0) begin bad++; $display("FAIL sat_bot_wrap: got %b want 0", bs.wrap); end
    total++; if (bs.ovf !== 1'b1) begin bad++; $display("FAIL sat_bot_ovf: got %b want 1", bs.ovf); end
    bs.en = 1'b0;
  endtask

  task automatic test_load;
    int lv[5] = '{3, 7, 6, 0, 5};
    int ec[5] = '{3, 5, 5, 0, 5};
    // b6 sits at 5 with ovf set; en/up stay active to show load wins.
    b6.en = 1'b1; b6.up = 1'b1; b6.load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b6.load_val = lv[i][2:0];
      #1;
      total++; if (b6.tc !== 1'b0) begin bad++; $display("FAIL load_tc vec%0d: got %b want 0", i, b6.tc); end
      tick();
      total++; if (b6.count !== ec[i][2:0]) begin bad++; $display("FAIL load_count vec%0d: got %0d want %0d", i, b6.count, ec[i]); end
      total++; if (b6.ovf !== 1'b0) begin bad++; $display("FAIL load_ovf vec%0d: got %b want 0", i, b6.ovf); end
    end
    b6.load = 1'b0;
    tick();
    total++; if (b6.count !== 3'd0 || b6.wrap !== 1'b1) begin bad++; $display("FAIL load_then_wrap: got count=%0d wrap=%b want 0/1", b6.count, b6.wrap); end
    b6.load = 1'b1; b6.load_val = 3'd2;
    tick();
    total++; if (b6.count !== 3'd2) begin bad++; $display("FAIL load_after_wrap_count: got %0d want 2", b6.count); end
    total++; if (b6.wrap !== 1'b0 || b6.ovf !== 1'b0) begin bad++; $display("FAIL load_after_wrap_flags: got wrap=%b ovf=%b want 0/0", b6.wrap, b6.ovf); end
    rst = 1'b1; b6.load_val = 3'd1;
    tick();
    total++; if (b6.count !== 3'd3) begin bad++; $display("FAIL load_vs_rst: got %0d want 3", b6.count); end
    rst = 1'b0; b6.load = 1'b0; b6.en = 1'b0;
  endtask

  task automatic test_enable_gating;
    int pe[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int ec[8] = '{1, 1, 2, 3, 3, 3, 4, 4};
    b8.load = 1'b1; b8.load_val = 3'd6;
    tick();
    b8.load = 1'b0; b8.en = 1'b1; b8.up = 1'b1;
    tick();
    tick();
    total++; if (b8.count !== 3'd0 || b8.ovf !== 1'b1) begin bad++; $display("FAIL gate_prewrap: got count=%0d ovf=%b want 0/1", b8.count, b8.ovf); end
    for (int i = 0; i < 8; i++) begin
      b8.en = pe[i][0];
      tick();
      total++; if (b8.count !== ec[i][2:0]) begin bad++; $display("FAIL gate_count step%0d: got %0d want %0d", i, b8.count, ec[i]); end
      total++; if (b8.wrap !== 1'b0) begin bad++; $display("FAIL gate_wrap step%0d: got %b want 0", i, b8.wrap); end
    end
    rst = 1'b1; b8.en = 1'b1;
    tick();
    total++; if (b8.count !== 3'd0 || b8.wrap !== 1'b0 || b8.ovf !== 1'b0) begin bad++; $display("FAIL midreset: got count=%0d wrap=%b ovf=%b want 0/0/0", b8.count, b8.wrap, b8.ovf); end
    rst = 1'b0;
    tick();
    total++; if (b8.count !== 3'd1) begin bad++; $display("FAIL post_reset_step: got %0d want 1", b8.count); end
    b8.en = 1'b0;
  endtask

  task automatic test_cascade;
    int hw = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0; bl.en = 1'b1; bl.up = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      total++; if ({bh.count, bl.count} !== 6'((i + 1) % 64)) begin bad++; $display("FAIL cascade_count step%0d: got %0d want %0d", i, {bh.count, bl.count}, (i + 1) % 64); end
      if (bh.wrap === 1'b1) hw++;
    end
    total++; if (bh.wrap !== 1'b1) begin bad++; $display("FAIL cascade_hi_wrap_last: got %b want 1", bh.wrap); end
    total++; if (hw != 1) begin bad++; $display("FAIL cascade_hi_wrap_pulses: got %0d want 1", hw); end
    bl.en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    b8.en = 1'b0; b8.up = 1'b1; b8.load = 1'b0; b8.load_val = '0;
    b6.en = 1'b0; b6.up = 1'b1; b6.load = 1'b0; b6.load_val = '0;
    bs.en = 1'b0; bs.up = 1'b1; bs.load = 1'b0; bs.load_val = '0;
    bl.en = 1'b0; bl.up = 1'b1; bl.load = 1'b0; bl.load_val = '0;
    #2;
    test_reset();
    test_up_count();
    test_down_count();
    test_saturate();
    test_load();
    test_enable_gating();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
